// File: rtl/waveform_framebuffer_controller.sv
// Single-port arbiter for the double-buffered 1-bit waveform bitmap RAM: clears banks,
// serves plot read-modify-writes into the draw bank and swaps banks on VSYNC.
module waveform_framebuffer_controller #(
    parameter int ADDRESS_LENGTH  = 14,
    parameter int WORDS_PER_FRAME = 13848,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      vsync,
    input  logic [ADDRESS_LENGTH-1:0] plot_word_address,
    input  logic [4:0]                plot_bit_offset,
    input  logic                      plot_valid,
    output logic                      plot_ready,
    output logic [ADDRESS_LENGTH:0]   mem_addr,
    output logic                      mem_rd_en,
    input  logic [31:0]               mem_rdata,
    output logic                      mem_wr_en,
    output logic [31:0]               mem_wdata,
    output logic                      display_bank,
    output logic                      frame_start,
    output logic                      clearing,
    output logic [15:0]               dropped_count
);

    localparam int CNT_W = ADDRESS_LENGTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(WORDS_PER_FRAME);
    localparam logic [CNT_W-1:0] BOTH_WORDS  = CNT_W'(2 * WORDS_PER_FRAME);
    localparam logic [OCC_W-1:0] FIFO_FULL   = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT_CLEAR, S_CLEAR, S_IDLE, S_RMW_RD, S_RMW_WAIT, S_RMW_WR
    } state_t;

    typedef struct packed {
        logic [ADDRESS_LENGTH-1:0] word;
        logic [4:0]                bit_idx;
    } plot_t;

    state_t                  r_state, w_next_state;
    logic [CNT_W-1:0]        r_cnt, w_next_cnt;
    plot_t                   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]        r_occ, w_next_occ;
    logic                    r_vsync_prev, r_swap_pending;
    logic [ADDRESS_LENGTH:0] r_rmw_addr, w_next_rmw_addr;
    logic [4:0]              r_rmw_bit, w_next_rmw_bit;

    logic                    r_plot_ready, r_mem_rd_en, r_mem_wr_en;
    logic [ADDRESS_LENGTH:0] r_mem_addr, w_mem_addr;
    logic [31:0]             r_mem_wdata, w_mem_wdata;
    logic                    r_display_bank, r_frame_start, r_clearing;
    logic [15:0]             r_dropped_count;

    logic                      w_addr_ok, w_push, w_drop, w_pop, w_serve_swap, w_vsync_rise;
    logic                      w_mem_rd_en, w_mem_wr_en, w_frame_start, w_clearing;
    logic                      w_next_bank, w_next_ready, w_init_upper;
    logic [ADDRESS_LENGTH-1:0] w_init_word;
    plot_t                     w_head;

    assign plot_ready    = r_plot_ready;
    assign mem_addr      = r_mem_addr;
    assign mem_rd_en     = r_mem_rd_en;
    assign mem_wr_en     = r_mem_wr_en;
    assign mem_wdata     = r_mem_wdata;
    assign display_bank  = r_display_bank;
    assign frame_start   = r_frame_start;
    assign clearing      = r_clearing;
    assign dropped_count = r_dropped_count;

    assign w_addr_ok    = {1'b0, plot_word_address} < FRAME_WORDS;
    assign w_push       = plot_valid & r_plot_ready & w_addr_ok;
    assign w_drop       = plot_valid & ~(r_plot_ready & w_addr_ok);
    assign w_vsync_rise = vsync & ~r_vsync_prev;
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_init_upper = (r_cnt >= FRAME_WORDS);
    assign w_init_word  = w_init_upper ? ADDRESS_LENGTH'(r_cnt - FRAME_WORDS)
                                       : r_cnt[ADDRESS_LENGTH-1:0];

    // Outputs are computed for the state being entered and registered, so r_state
    // always names the state whose strobes are visible on the RAM port.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_rmw_addr = r_rmw_addr;
        w_next_rmw_bit  = r_rmw_bit;
        w_next_bank     = r_display_bank;
        w_pop           = 1'b0;
        w_serve_swap    = 1'b0;
        w_mem_addr      = '0;
        w_mem_rd_en     = 1'b0;
        w_mem_wr_en     = 1'b0;
        w_mem_wdata     = '0;
        w_frame_start   = 1'b0;
        w_clearing      = 1'b0;
        case (r_state)
            S_INIT_CLEAR: begin
                if (r_cnt < BOTH_WORDS) begin
                    w_mem_wr_en = 1'b1;
                    w_mem_addr  = {w_init_upper, w_init_word};
                    w_clearing  = 1'b1;
                    w_next_cnt  = r_cnt + CNT_W'(1);
                end else begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt < FRAME_WORDS) begin
                    w_mem_wr_en = 1'b1;
                    w_mem_addr  = {~r_display_bank, r_cnt[ADDRESS_LENGTH-1:0]};
                    w_clearing  = 1'b1;
                    w_next_cnt  = r_cnt + CNT_W'(1);
                end else begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            end
            S_RMW_RD: begin
                w_next_state = S_RMW_WAIT;
                w_mem_addr   = r_rmw_addr;
            end
            S_RMW_WAIT: begin
                w_next_state = S_RMW_WR;
                w_mem_wr_en  = 1'b1;
                w_mem_addr   = r_rmw_addr;
                w_mem_wdata  = mem_rdata | (32'd1 << r_rmw_bit);
            end
            // The write cycle dispatches like IDLE so a queued read lands right after it.
            S_IDLE, S_RMW_WR: begin
                if (r_swap_pending) begin
                    w_serve_swap  = 1'b1;
                    w_next_bank   = ~r_display_bank;
                    w_frame_start = 1'b1;
                    w_next_state  = S_CLEAR;
                    w_mem_wr_en   = 1'b1;
                    w_mem_addr    = {r_display_bank, {ADDRESS_LENGTH{1'b0}}};
                    w_clearing    = 1'b1;
                    w_next_cnt    = CNT_W'(1);
                end else if (r_occ != '0) begin
                    w_pop           = 1'b1;
                    w_next_state    = S_RMW_RD;
                    w_next_rmw_addr = {~r_display_bank, w_head.word};
                    w_next_rmw_bit  = w_head.bit_idx;
                    w_mem_rd_en     = 1'b1;
                    w_mem_addr      = {~r_display_bank, w_head.word};
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        w_next_occ   = w_serve_swap ? '0 : r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        w_next_ready = (w_next_state != S_INIT_CLEAR) && (w_next_occ != FIFO_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_INIT_CLEAR;
            r_cnt           <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            r_vsync_prev    <= 1'b0;
            r_swap_pending  <= 1'b0;
            r_rmw_addr      <= '0;
            r_rmw_bit       <= '0;
            r_plot_ready    <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_rd_en     <= 1'b0;
            r_mem_wr_en     <= 1'b0;
            r_mem_wdata     <= '0;
            r_display_bank  <= 1'b0;
            r_frame_start   <= 1'b0;
            r_clearing      <= 1'b0;
            r_dropped_count <= '0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_occ          <= w_next_occ;
            r_vsync_prev   <= vsync;
            r_swap_pending <= w_serve_swap ? 1'b0 : (r_swap_pending | w_vsync_rise);
            r_rmw_addr     <= w_next_rmw_addr;
            r_rmw_bit      <= w_next_rmw_bit;
            r_plot_ready   <= w_next_ready;
            r_mem_addr     <= w_mem_addr;
            r_mem_rd_en    <= w_mem_rd_en;
            r_mem_wr_en    <= w_mem_wr_en;
            r_mem_wdata    <= w_mem_wdata;
            r_display_bank <= w_next_bank;
            r_frame_start  <= w_frame_start;
            r_clearing     <= w_clearing;
            if (w_serve_swap) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop && r_dropped_count != 16'hFFFF)
                r_dropped_count <= r_dropped_count + 16'd1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and occupancy alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= '{word: plot_word_address, bit_idx: plot_bit_offset};
    end

endmodule

// File: tb/tb_waveform_framebuffer_controller.sv
// Scoreboard bench: expected RAM writes are queued as stimulus is driven and matched
// against every mem_wr_en cycle; a small behavioural RAM answers the read port.
module tb_waveform_framebuffer_controller;

    localparam int AL  = 14;
    localparam int WPF = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          vsync;
    logic [AL-1:0] plot_word_address;
    logic [4:0]    plot_bit_offset;
    logic          plot_valid;
    logic          plot_ready;
    logic [AL:0]   mem_addr;
    logic          mem_rd_en;
    logic [31:0]   mem_rdata;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;
    logic          display_bank;
    logic          frame_start;
    logic          clearing;
    logic [15:0]   dropped_count;

    waveform_framebuffer_controller #(
        .ADDRESS_LENGTH (AL),
        .WORDS_PER_FRAME(WPF),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .vsync            (vsync),
        .plot_word_address(plot_word_address),
        .plot_bit_offset  (plot_bit_offset),
        .plot_valid       (plot_valid),
        .plot_ready       (plot_ready),
        .mem_addr         (mem_addr),
        .mem_rd_en        (mem_rd_en),
        .mem_rdata        (mem_rdata),
        .mem_wr_en        (mem_wr_en),
        .mem_wdata        (mem_wdata),
        .display_bank     (display_bank),
        .frame_start      (frame_start),
        .clearing         (clearing),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AL:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] model [2][WPF];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_drops = 0;

    // Behavioural RAM with one-cycle read latency plus a preload port.
    logic [31:0] ram [0:32767];
    logic        pre_en = 1'b0;
    logic [AL:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)    ram[pre_addr] <= pre_data;
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        wr_t e;
        if (mem_wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data)
                    $display("FAIL write_match: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                else
                    n_pass++;
            end
        end
        if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) begin
            n_checks++;
            $display("FAIL rd_wr_exclusive: got both strobes high at addr=%h, expected at most one", mem_addr);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic push_clear(input logic bank);
        for (int i = 0; i < WPF; i++) begin
            exp_q.push_back('{addr: {bank, AL'(i)}, data: 32'h0});
            model[bank][i] = 32'h0;
        end
    endtask

    task automatic push_plot(input logic bank, input int word, input int b);
        model[bank][word] = model[bank][word] | (32'd1 << b);
        exp_q.push_back('{addr: {bank, AL'(word)}, data: model[bank][word]});
    endtask

    task automatic drive_plot(input int word, input int b);
        plot_word_address = AL'(word);
        plot_bit_offset   = 5'(b);
        plot_valid        = 1'b1;
        @(negedge clk); #1;
        plot_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && clearing === 1'b0 && mem_wr_en === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_vsync_and_find_frame(output bit found);
        vsync = 1'b1;
        @(negedge clk); #1;
        vsync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({mem_rd_en, mem_wr_en, frame_start, clearing, plot_ready, display_bank} !== 6'b0)
            $display("FAIL reset_flags: got %b, expected 000000",
                     {mem_rd_en, mem_wr_en, frame_start, clearing, plot_ready, display_bank});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0)
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h, expected 0", mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (dropped_count !== 16'd0)
            $display("FAIL reset_dropped: got %0d, expected 0", dropped_count);
        else n_pass++;
    endtask

    task automatic test_init_clear;
        int clr_cycles = 0;
        bit ok = 1'b0;
        push_clear(1'b0);
        push_clear(1'b1);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (clearing === 1'b1) clr_cycles++;
            else if (clr_cycles > 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL init_clear_done: got no end of clearing, expected end within 100 cycles");
        else n_pass++;
        n_checks++;
        if (clr_cycles != 2 * WPF)
            $display("FAIL init_clear_len: got %0d clearing cycles, expected %0d", clr_cycles, 2 * WPF);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL init_clear_writes: got %0d writes missing, expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (plot_ready !== 1'b1)
            $display("FAIL init_ready: got plot_ready=%b, expected 1", plot_ready);
        else n_pass++;
    endtask

    task automatic test_plot_basic;
        bit found = 1'b0;
        bit ok;
        pre_addr = 15'h4005;
        pre_data = 32'h0000_0001;
        pre_en   = 1'b1;
        @(negedge clk); #1;
        pre_en = 1'b0;
        model[1][5] = 32'h0000_0001;
        push_plot(1'b1, 5, 3);
        drive_plot(5, 3);
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (!found || mem_addr !== 15'h4005)
            $display("FAIL plot_read: got found=%b addr=%h, expected read at 4005", found, mem_addr);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0)
            $display("FAIL plot_wait: got rd=%b wr=%b, expected both 0", mem_rd_en, mem_wr_en);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 15'h4005 || mem_wdata !== 32'h0000_0009)
            $display("FAIL plot_write: got wr=%b addr=%h data=%h, expected 1 4005 00000009",
                     mem_wr_en, mem_addr, mem_wdata);
        else n_pass++;
        wait_drain(10, ok);
        n_checks++;
        if (!ok || dropped_count !== 16'(exp_drops))
            $display("FAIL plot_basic_done: got drained=%b dropped=%0d, expected 1 %0d", ok, dropped_count, exp_drops);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        push_plot(1'b1, 7, 0);
        push_plot(1'b1, 7, 31);
        drive_plot(7, 0);
        drive_plot(7, 31);
        wait_drain(20, ok);
        @(negedge clk); #1;
        n_checks++;
        if (!ok || ram[15'h4007] !== 32'h8000_0001)
            $display("FAIL b2b_word: got drained=%b word=%h, expected 1 80000001", ok, ram[15'h4007]);
        else n_pass++;
        n_checks++;
        if (dropped_count !== 16'(exp_drops))
            $display("FAIL b2b_dropped: got %0d, expected %0d", dropped_count, exp_drops);
        else n_pass++;
    endtask

    task automatic test_swap;
        bit found;
        bit ok;
        push_clear(1'b0);
        pulse_vsync_and_find_frame(found);
        n_checks++;
        if (!found || display_bank !== 1'b1)
            $display("FAIL swap_frame: got found=%b bank=%b, expected 1 1", found, display_bank);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (frame_start !== 1'b0 || clearing !== 1'b1)
            $display("FAIL swap_pulse: got frame_start=%b clearing=%b, expected 0 1", frame_start, clearing);
        else n_pass++;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("FAIL swap_clear: got %0d writes missing, expected 0", exp_q.size());
        else n_pass++;
        push_plot(1'b0, 10, 4);
        drive_plot(10, 4);
        wait_drain(20, ok);
        n_checks++;
        if (!ok) $display("FAIL swap_plot_bank0: got %0d writes missing, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_clear_drops;
        bit found;
        bit ok;
        push_clear(1'b1);
        pulse_vsync_and_find_frame(found);
        n_checks++;
        if (!found || display_bank !== 1'b0)
            $display("FAIL drops_frame: got found=%b bank=%b, expected 1 0", found, display_bank);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) push_plot(1'b1, i + 1, i + 2);
            else exp_drops++;
            drive_plot(i + 1, i + 2);
        end
        n_checks++;
        if (clearing !== 1'b1)
            $display("FAIL drops_in_clear: got clearing=%b after strobes, expected 1", clearing);
        else n_pass++;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("FAIL drops_rmw: got %0d writes missing, expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (dropped_count !== 16'(exp_drops))
            $display("FAIL drops_count: got %0d, expected %0d", dropped_count, exp_drops);
        else n_pass++;
    endtask

    task automatic test_out_of_range;
        int accesses = 0;
        bit ok;
        exp_drops++;
        drive_plot(WPF, 0);
        for (int i = 0; i < 8; i++) begin
            if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1) accesses++;
            @(negedge clk); #1;
        end
        n_checks++;
        if (accesses != 0 || dropped_count !== 16'(exp_drops))
            $display("FAIL out_of_range: got accesses=%0d dropped=%0d, expected 0 %0d",
                     accesses, dropped_count, exp_drops);
        else n_pass++;
        push_plot(1'b1, WPF - 1, 2);
        drive_plot(WPF - 1, 2);
        wait_drain(20, ok);
        n_checks++;
        if (!ok || dropped_count !== 16'(exp_drops))
            $display("FAIL last_word: got drained=%b dropped=%0d, expected 1 %0d", ok, dropped_count, exp_drops);
        else n_pass++;
    endtask

    task automatic test_reset_mid_rmw;
        bit found = 1'b0;
        bit ok;
        drive_plot(2, 1);
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (!found) $display("FAIL rst_rmw_read: got no read, expected read within 10 cycles");
        else n_pass++;
        resetn = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({mem_rd_en, mem_wr_en, clearing, plot_ready, frame_start, display_bank} !== 6'b0 ||
            dropped_count !== 16'd0)
            $display("FAIL rst_abort: got flags=%b dropped=%0d, expected 000000 0",
                     {mem_rd_en, mem_wr_en, clearing, plot_ready, frame_start, display_bank}, dropped_count);
        else n_pass++;
        exp_drops = 0;
        push_clear(1'b0);
        push_clear(1'b1);
        resetn = 1'b1;
        wait_drain(80, ok);
        n_checks++;
        if (!ok || plot_ready !== 1'b1)
            $display("FAIL rst_reinit: got drained=%b plot_ready=%b, expected 1 1", ok, plot_ready);
        else n_pass++;
    endtask

    initial begin
        resetn            = 1'b0;
        vsync             = 1'b0;
        plot_valid        = 1'b0;
        plot_word_address = '0;
        plot_bit_offset   = '0;
        test_reset();
        test_init_clear();
        test_plot_basic();
        test_back_to_back();
        test_swap();
        test_clear_drops();
        test_out_of_range();
        test_reset_mid_rmw();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL final_queue: got %0d pending writes, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
